// File: rtl/seq_multiplier.sv
// Multi-cycle 32x32 shift-add multiplier (MULT/MULTU) for the EX stage.
// Each iteration adds the multiplicand through a local 32-bit carry-select adder.

module seq_mul_csa32 (
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    input  logic        i_ci,
    output logic [31:0] o_sum,
    output logic        o_co
);
    logic [4:0] w_c;
    assign w_c[0] = i_ci;

    // Each byte computes both carry-in outcomes; the incoming carry picks one.
    for (genvar g = 0; g < 4; g++) begin : g_blk
        logic [8:0] w_s0;
        logic [8:0] w_s1;
        assign w_s0 = {1'b0, i_a[g*8 +: 8]} + {1'b0, i_b[g*8 +: 8]};
        assign w_s1 = {1'b0, i_a[g*8 +: 8]} + {1'b0, i_b[g*8 +: 8]} + 9'd1;
        assign o_sum[g*8 +: 8] = w_c[g] ? w_s1[7:0] : w_s0[7:0];
        assign w_c[g+1]        = w_c[g] ? w_s1[8]   : w_s0[8];
    end

    assign o_co = w_c[4];
endmodule

module seq_multiplier #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_t;

    state_t             r_state;
    state_t             w_next;
    logic [WIDTH-1:0]   r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [2*WIDTH-1:0] r_acc;
    logic [5:0]         r_cnt;
    logic               r_neg;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;

    logic               w_accept;
    logic [WIDTH-1:0]   w_abs_a;
    logic [WIDTH-1:0]   w_abs_b;
    logic [WIDTH-1:0]   w_sum;
    logic               w_co;

    seq_mul_csa32 u_add (
        .i_a   (r_acc[2*WIDTH-1:WIDTH]),
        .i_b   (r_mcand),
        .i_ci  (1'b0),
        .o_sum (w_sum),
        .o_co  (w_co)
    );

    assign w_accept = start && (r_state == S_IDLE || r_state == S_DONE);
    // 0x80000000 negates to itself, which read as unsigned is the right magnitude.
    assign w_abs_a  = (is_signed && a[WIDTH-1]) ? (~a + 1'b1) : a;
    assign w_abs_b  = (is_signed && b[WIDTH-1]) ? (~b + 1'b1) : b;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = S_RUN;
            S_RUN:   if (r_cnt == 6'd31) w_next = S_FIX;
            S_FIX:   w_next = S_DONE;
            S_DONE:  w_next = start ? S_RUN : S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_neg    <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_mcand  <= w_abs_a;
                r_mplier <= w_abs_b;
                r_neg    <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                r_acc    <= '0;
                r_cnt    <= '0;
            end else if (r_state == S_RUN) begin
                // Adder carry-out becomes the new top bit as the accumulator shifts right.
                r_acc    <= r_mplier[0] ? {w_co, w_sum, r_acc[WIDTH-1:1]}
                                        : {1'b0, r_acc[2*WIDTH-1:1]};
                r_mplier <= r_mplier >> 1;
                r_cnt    <= r_cnt + 6'd1;
            end else if (r_state == S_FIX) begin
                {r_hi, r_lo} <= r_neg ? (~r_acc + 1'b1) : r_acc;
            end
        end
    end

    assign busy = (r_state == S_RUN) || (r_state == S_FIX);
    assign done = (r_state == S_DONE);
    assign hi   = r_hi;
    assign lo   = r_lo;
endmodule

// File: tb/tb_seq_multiplier.sv
// Randomized and directed bench for seq_multiplier against a 64-bit arithmetic reference.
module tb_seq_multiplier;
    logic        clk = 1'b0;
    logic        rst, start, is_signed;
    logic [31:0] a, b;
    logic        busy, done;
    logic [31:0] hi, lo;
    int unsigned n_vec = 0, n_err = 0;
    logic [63:0] last = '0;

    always #5 clk = ~clk;

    seq_multiplier #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .is_signed(is_signed),
        .a(a), .b(b), .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] ref_mul(input logic [31:0] x, input logic [31:0] y,
                                            input logic s);
        longint          sx, sy;
        longint unsigned ux, uy;
        if (s) begin
            sx = longint'($signed(x));
            sy = longint'($signed(y));
            return 64'(sx * sy);
        end
        ux = 64'(x);
        uy = 64'(y);
        return ux * uy;
    endfunction

    // One multiply; glitch>0 pulses a spurious start with other operands at that cycle.
    task automatic mul(input logic [31:0] x, input logic [31:0] y, input logic s,
                       input int glitch);
        int          n;
        logic [63:0] exp;
        exp = ref_mul(x, y, s);
        @(negedge clk);
        start = 1'b1; a = x; b = y; is_signed = s;
        @(negedge clk);
        a = $urandom; b = $urandom; is_signed = 1'($urandom);
        n = 1;
        while (!done && n < 40) begin
            chk("busy_run", {63'd0, busy}, 64'd1);
            chk("hold", {hi, lo}, last);
            start = (n == glitch);
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        chk("latency", 64'(n), 64'd34);
        chk("busy_in_done", {63'd0, busy}, 64'd0);
        chk("product", {hi, lo}, exp);
        last = exp;
        @(negedge clk);
        chk("done_pulse", {63'd0, done}, 64'd0);
        chk("hold_idle", {hi, lo}, last);
    endtask

    initial begin
        int          n;
        bit          seen;
        logic [31:0] x, y;
        rst = 1'b1; start = 1'b1; is_signed = 1'b0; a = 32'd3; b = 32'd5;
        repeat (2) @(negedge clk);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_hilo", {hi, lo}, 64'd0);
        rst = 1'b0; start = 1'b0;
        @(negedge clk);
        chk("idle_busy", {63'd0, busy}, 64'd0);

        mul(32'd3, 32'd5, 1'b0, 0);
        chk("3x5_lo", 64'(lo), 64'h0000_000F);
        mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0);
        chk("ffxff_u", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
        mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 0);
        chk("m1xm1_s", {hi, lo}, 64'h0000_0000_0000_0001);
        mul(32'h8000_0000, 32'h8000_0000, 1'b1, 0);
        chk("minxmin", {hi, lo}, 64'h4000_0000_0000_0000);
        mul(32'hFFFF_FFFD, 32'h0000_0005, 1'b1, 0);
        chk("m3x5", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFF1);
        mul(32'h0, 32'h8000_0000, 1'b1, 0);
        chk("0xmin", {hi, lo}, 64'h0);
        mul(32'h0001_2345, 32'h0000_6789, 1'b0, 10);

        // start held high: a new result every 34 cycles
        @(negedge clk);
        start = 1'b1; a = 32'd7; b = 32'd6; is_signed = 1'b0;
        for (int k = 0; k < 3; k++) begin
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!done && n < 40);
            if (k == 2) start = 1'b0;
            chk("b2b_gap", 64'(n), 64'd34);
            chk("b2b_lo", {hi, lo}, 64'd42);
        end
        last = 64'd42;
        @(negedge clk);

        // reset mid-RUN, asserted ahead of edge E+10
        start = 1'b1; a = 32'd9; b = 32'd9; is_signed = 1'b0;
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_busy", {63'd0, busy}, 64'd0);
        chk("mid_rst_done", {63'd0, done}, 64'd0);
        chk("mid_rst_hilo", {hi, lo}, 64'd0);
        last = '0;
        seen = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (done || busy) seen = 1'b1;
        end
        chk("no_done_after_rst", {63'd0, seen}, 64'd0);
        mul(32'd2, 32'd2, 1'b0, 0);
        chk("2x2", 64'(lo), 64'd4);

        for (int i = 0; i < 1000; i++) begin
            x = $urandom;
            y = $urandom;
            if (i % 8 == 0) x = {x[31], 31'd0};
            if (i % 8 == 1) y = 32'(-int'($urandom_range(3)));
            mul(x, y, 1'($urandom), ($urandom_range(3) == 0) ? int'($urandom_range(1, 33)) : 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
